// File: rtl/autobaud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : autobaud_pkg
// Purpose  : Shared encodings for the UART auto-baud controller: FSM state
//            codes (3 bits) and the error codes reported on err_code.
// Revision : 1.0  initial release
// ============================================================================
package autobaud_pkg;

  // State codes, 3 bits wide
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARM       = 3'd1;
  localparam logic [2:0] ST_WAIT_EDGE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_LOAD      = 3'd4;
  localparam logic [2:0] ST_CHECK     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERR       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ARM       = ST_ARM,
    S_WAIT_EDGE = ST_WAIT_EDGE,
    S_MEASURE   = ST_MEASURE,
    S_LOAD      = ST_LOAD,
    S_CHECK     = ST_CHECK,
    S_DONE      = ST_DONE,
    S_ERR       = ST_ERR
  } state_e;

  // Error codes
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

endpackage : autobaud_pkg
`default_nettype wire

// File: rtl/rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : rx_sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous serial line plus
//            fall/rise detection on the synchronised copy. All flops reset
//            to 1 so an idle (high) line produces no spurious edge.
// Ports    : clk   in  clock
//            rst   in  asynchronous reset, active low
//            rx    in  raw asynchronous line
//            rx_s  out synchronised line
//            fall  out rx_s went 1 -> 0 this cycle
//            rise  out rx_s went 0 -> 1 this cycle
// Revision : 1.0  initial release
// ============================================================================
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

endmodule : rx_sync_edge
`default_nettype wire

// File: rtl/autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : autobaud_ctrl
// Purpose  : Sequences the auto-baud measurement datapath (free counter +
//            result register). Once armed it times the low period of the
//            start bit on rx, loads the count into the datapath register and
//            range-checks the loaded value N.
// Ports    : clk        in  measurement clock (shared with the datapath)
//            rst        in  asynchronous reset, active low
//            start      in  arm request, honoured in IDLE only
//            abort      in  synchronous abort, returns to IDLE next cycle
//            rx         in  raw serial line, idle high
//            N          in  datapath register value, fed back for checking
//            cnt_en     out datapath counter enable
//            cnt_rst    out datapath counter clear
//            ld_en      out datapath register load
//            busy       out high outside IDLE
//            done       out 1-cycle pulse, valid N measured
//            err        out 1-cycle pulse, measurement failed
//            err_code   out 01 too short, 10 overflow; held until next start
//            baud_valid out set after done, cleared by start/abort
// Revision : 1.0  initial release
// ============================================================================
module autobaud_ctrl
  import autobaud_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             rx,
  input  logic [CNT_W-1:0] N,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic             ld_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             baud_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(MIN_COUNT);

  logic rx_s;
  logic fall;
  logic rise_unused;

  rx_sync_edge u_rx_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall),
    .rise (rise_unused)
  );

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] meas_cnt_q,   meas_cnt_d;
  logic [1:0]       err_code_q,   err_code_d;
  logic             baud_valid_q, baud_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      meas_cnt_q   <= '0;
      err_code_q   <= ERR_NONE;
      baud_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      meas_cnt_q   <= meas_cnt_d;
      err_code_q   <= err_code_d;
      baud_valid_q <= baud_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    meas_cnt_d   = meas_cnt_q;
    err_code_d   = err_code_q;
    baud_valid_d = baud_valid_q;

    if (abort) begin
      state_d      = S_IDLE;
      baud_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d      = S_ARM;
            baud_valid_d = 1'b0;
            err_code_d   = ERR_NONE;
          end
        end
        // Refuse to look for an edge until the line has been seen high,
        // otherwise arming mid-low would time a partial pulse.
        S_ARM: begin
          if (rx_s) state_d = S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (fall) begin
            state_d    = S_MEASURE;
            meas_cnt_d = '0;
          end
        end
        // meas_cnt shadows the datapath counter. When it would reach its
        // maximum with the line still low, one more cycle would wrap the
        // datapath counter, so stop here and flag overflow.
        S_MEASURE: begin
          if (meas_cnt_q != CNT_MAX) meas_cnt_d = meas_cnt_q + 1'b1;
          if (rx_s) begin
            state_d = S_LOAD;
          end else if (meas_cnt_d == CNT_MAX) begin
            state_d    = S_ERR;
            err_code_d = ERR_OVF;
          end
        end
        S_LOAD: begin
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (N < MIN_N) begin
            state_d    = S_ERR;
            err_code_d = ERR_SHORT;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d      = S_IDLE;
          baud_valid_d = 1'b1;
        end
        S_ERR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Moore decodes; the result pulses are masked by abort so an abort in
  // DONE/ERR leaves no trace.
  assign cnt_rst    = (state_q == S_IDLE) || (state_q == S_ARM) ||
                      (state_q == S_WAIT_EDGE);
  assign cnt_en     = (state_q == S_MEASURE);
  assign ld_en      = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !abort;
  assign err        = (state_q == S_ERR)  && !abort;
  assign err_code   = err_code_q;
  assign baud_valid = baud_valid_q;

endmodule : autobaud_ctrl
`default_nettype wire

// File: tb/tb_autobaud_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_autobaud_ctrl
// Purpose  : Directed self-checking bench for autobaud_ctrl, including a
//            behavioural model of the counter/register datapath it drives.
// Revision : 1.0  initial release
// ============================================================================
module tb_autobaud_ctrl;

  localparam int CNT_W     = 8;
  localparam int MIN_COUNT = 4;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             rx    = 1'b1;
  logic [CNT_W-1:0] N     = '0;
  logic             cnt_en, cnt_rst, ld_en, busy, done, err, baud_valid;
  logic [1:0]       err_code;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CNT_W-1:0] dp_cnt = '0;

  autobaud_ctrl #(
    .CNT_W     (CNT_W),
    .MIN_COUNT (MIN_COUNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .rx         (rx),
    .N          (N),
    .cnt_en     (cnt_en),
    .cnt_rst    (cnt_rst),
    .ld_en      (ld_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .baud_valid (baud_valid)
  );

  always #5 clk = ~clk;

  // Datapath: free counter plus result register
  always @(posedge clk) begin
    if (cnt_rst)     dp_cnt <= '0;
    else if (cnt_en) dp_cnt <= dp_cnt + 1'b1;
    if (ld_en)       N <= dp_cnt;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start for one cycle, then one cycle for ARM -> WAIT_EDGE on an idle line
  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Low pulse of len cycles; result pulse expected exactly 5 cycles after rise
  task automatic measure(input string tag, input int len, input bit exp_ok);
    rx = 1'b0;
    repeat (len) tick();
    rx = 1'b1;
    repeat (4) tick();
    check_eq({tag, "_early"}, {30'd0, done, err}, 32'd0);
    tick();
    check_eq({tag, "_done"}, {31'd0, done}, {31'd0, exp_ok});
    check_eq({tag, "_err"},  {31'd0, err},  {31'd0, !exp_ok});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;

    // Reset state
    #12;
    check_eq("rst_busy",    {31'd0, busy},    32'd0);
    check_eq("rst_cnt_rst", {31'd0, cnt_rst}, 32'd1);
    check_eq("rst_cnt_en",  {31'd0, cnt_en},  32'd0);
    check_eq("rst_ld_en",   {31'd0, ld_en},   32'd0);
    check_eq("rst_pulses",  {30'd0, done, err}, 32'd0);
    check_eq("rst_code",    {30'd0, err_code}, 32'd0);
    check_eq("rst_bv",      {31'd0, baud_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) tick();

    // Nominal 16-cycle measurement
    arm();
    check_eq("m16_busy",    {31'd0, busy},    32'd1);
    check_eq("m16_cnt_rst", {31'd0, cnt_rst}, 32'd1);
    measure("m16", 16, 1'b1);
    check_eq("m16_N",    {24'd0, N},        32'd16);
    check_eq("m16_code", {30'd0, err_code}, 32'd0);
    tick();
    check_eq("m16_bv",     {31'd0, baud_valid}, 32'd1);
    check_eq("m16_idle",   {31'd0, busy},       32'd0);

    // Too short: 2 cycles
    arm();
    check_eq("m2_bv_clr", {31'd0, baud_valid}, 32'd0);
    measure("m2", 2, 1'b0);
    check_eq("m2_code", {30'd0, err_code}, 32'd1);
    check_eq("m2_N",    {24'd0, N},        32'd2);
    check_eq("m2_bv",   {31'd0, baud_valid}, 32'd0);
    tick();

    // Overflow: 300 low cycles, error after 255 MEASURE cycles
    arm();
    rx = 1'b0;
    repeat (257) tick();
    check_eq("ovf_pre_err", {31'd0, err},    32'd0);
    check_eq("ovf_pre_en",  {31'd0, cnt_en}, 32'd1);
    tick();
    check_eq("ovf_err",  {31'd0, err},      32'd1);
    check_eq("ovf_code", {30'd0, err_code}, 32'd2);
    check_eq("ovf_en",   {31'd0, cnt_en},   32'd0);
    check_eq("ovf_N",    {24'd0, N},        32'd2);
    repeat (42) tick();
    rx = 1'b1;
    repeat (4) tick();
    check_eq("ovf_idle", {31'd0, busy}, 32'd0);

    // Start while line is low: held in ARM until high, then 10-cycle pulse
    rx = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check_eq("arm_code_clr", {30'd0, err_code}, 32'd0);
    check_eq("arm_busy",     {31'd0, busy},     32'd1);
    check_eq("arm_cnt_en",   {31'd0, cnt_en},   32'd0);
    rx = 1'b1;
    repeat (5) tick();
    measure("m10", 10, 1'b1);
    check_eq("m10_N", {24'd0, N}, 32'd10);
    tick();

    // Abort mid-MEASURE
    arm();
    rx = 1'b0;
    repeat (10) tick();
    check_eq("abt_meas", {31'd0, cnt_en}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abt_busy",    {31'd0, busy},    32'd0);
    check_eq("abt_cnt_rst", {31'd0, cnt_rst}, 32'd1);
    check_eq("abt_bv",      {31'd0, baud_valid}, 32'd0);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || err || busy) seen = 1'b1;
    end
    check_eq("abt_quiet", {31'd0, seen}, 32'd0);

    // Reset mid-MEASURE
    arm();
    rx = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check_eq("rstm_busy",    {31'd0, busy},    32'd0);
    check_eq("rstm_cnt_rst", {31'd0, cnt_rst}, 32'd1);
    check_eq("rstm_cnt_en",  {31'd0, cnt_en},  32'd0);
    tick();
    rst = 1'b1;
    rx  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || err || busy) seen = 1'b1;
    end
    check_eq("rstm_quiet", {31'd0, seen}, 32'd0);

    // start + abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("sa_idle", {31'd0, busy}, 32'd0);

    // Abort during DONE suppresses the pulse and baud_valid
    arm();
    rx = 1'b0;
    repeat (6) tick();
    rx = 1'b1;
    repeat (5) tick();
    abort = 1'b1;
    #1;
    check_eq("abd_done", {31'd0, done}, 32'd0);
    tick();
    abort = 1'b0;
    check_eq("abd_bv",   {31'd0, baud_valid}, 32'd0);
    check_eq("abd_busy", {31'd0, busy},       32'd0);

    // Back-to-back measurements
    arm();
    measure("b1", 16, 1'b1);
    tick();
    check_eq("b2b_bv1", {31'd0, baud_valid}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b2b_bv_drop", {31'd0, baud_valid}, 32'd0);
    check_eq("b2b_busy",    {31'd0, busy},       32'd1);
    tick();
    measure("b2", 8, 1'b1);
    check_eq("b2_N", {24'd0, N}, 32'd8);
    check_eq("b2_bv_pre", {31'd0, baud_valid}, 32'd0);
    tick();
    check_eq("b2_bv", {31'd0, baud_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_autobaud_ctrl
`default_nettype wire
